// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared codes, state encoding and request check for the load/store unit
package load_store_unit_pkg;

    // Access size codes as presented on Size_i
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Error codes reported on Err_Code_o
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_SIZE     = 2'b11;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_READ,
        ST_WRITE,
        ST_DONE
    } lsu_state_e;

    // Bad size beats misalignment, which beats out-of-range; limit is exclusive
    function automatic logic [1:0] check_request(input logic [1:0]  size,
                                                 input logic [31:0] addr,
                                                 input logic [31:0] base,
                                                 input logic [31:0] limit);
        logic [1:0] code;
        code = ERR_NONE;
        if (size == SZ_RSVD) begin
            code = ERR_SIZE;
        end else if ((size == SZ_HALF && addr[0]) ||
                     (size == SZ_WORD && addr[1:0] != 2'b00)) begin
            code = ERR_MISALIGN;
        end else if (addr < base || addr >= limit) begin
            code = ERR_RANGE;
        end
        return code;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane extraction/extension for loads and lane merge for stores
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] read_word_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_word_o
);

    logic [31:0] shifted;

    // Little-endian: the addressed lane is moved down to bit 0
    assign shifted = read_word_i >> {addr_lo_i, 3'b000};

    // Extend the selected lane for loads; overlay store bytes onto the read word
    always_comb begin
        load_data_o  = '0;
        merge_word_o = read_word_i;
        case (size_i)
            SZ_BYTE: begin
                load_data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
                merge_word_o[{addr_lo_i, 3'b000} +: 8] = store_data_i[7:0];
            end
            SZ_HALF: begin
                load_data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
                merge_word_o[{addr_lo_i[1], 4'b0000} +: 16] = store_data_i[15:0];
            end
            SZ_WORD: begin
                load_data_o  = read_word_i;
                merge_word_o = store_data_i;
            end
            default: begin
                load_data_o  = '0;
                merge_word_o = read_word_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator with sub-word access, RMW stores and request checking
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
    parameter int          MEMORY_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Req_i,
    input  logic                  Write_i,
    input  logic [1:0]            Size_i,
    input  logic                  Unsigned_i,
    input  logic [31:0]           Address_i,
    input  logic [DATA_WIDTH-1:0] Write_Data_i,
    output logic                  Ready_o,
    output logic                  Done_o,
    output logic [DATA_WIDTH-1:0] Load_Data_o,
    output logic                  Error_o,
    output logic [1:0]            Err_Code_o,
    output logic [31:0]           Mem_Address_o,
    output logic                  Mem_Write_Enable_o,
    output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
    input  logic [DATA_WIDTH-1:0] Mem_Read_Data_i
);

    localparam logic [31:0] LIMIT_ADDR = BASE_ADDR + 32'(4 * MEMORY_DEPTH);

    lsu_state_e  state_q, state_d;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  err_code_q;
    logic [31:0] merged_q;
    logic [31:0] load_data_q;

    logic        accept;
    logic [1:0]  req_err;
    logic [31:0] lane_load;
    logic [31:0] lane_merge;

    assign accept  = (state_q == ST_IDLE) && Req_i;
    assign req_err = check_request(Size_i, Address_i, BASE_ADDR, LIMIT_ADDR);

    lsu_lane_align u_lane_align (
        .size_i       (size_q),
        .unsigned_i   (unsigned_q),
        .addr_lo_i    (addr_q[1:0]),
        .read_word_i  (Mem_Read_Data_i),
        .store_data_i (wdata_q),
        .load_data_o  (lane_load),
        .merge_word_o (lane_merge)
    );

    // State register; async reset drops write enable the moment reset rises
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state and all outputs decoded from the registered state only
    always_comb begin
        state_d            = state_q;
        Ready_o            = 1'b0;
        Done_o             = 1'b0;
        Error_o            = 1'b0;
        Err_Code_o         = ERR_NONE;
        Mem_Write_Enable_o = 1'b0;
        Mem_Write_Data_o   = '0;
        case (state_q)
            ST_IDLE: begin
                Ready_o = 1'b1;
                if (Req_i) begin
                    if (req_err != ERR_NONE)  state_d = ST_DONE;
                    else if (!Write_i)        state_d = ST_LOAD;
                    else if (Size_i == SZ_WORD) state_d = ST_WRITE;
                    else                      state_d = ST_RMW_READ;
                end
            end
            ST_LOAD:     state_d = ST_DONE;
            ST_RMW_READ: state_d = ST_WRITE;
            ST_WRITE: begin
                Mem_Write_Enable_o = 1'b1;
                Mem_Write_Data_o   = (size_q == SZ_WORD) ? wdata_q : merged_q;
                state_d            = ST_DONE;
            end
            ST_DONE: begin
                Done_o     = 1'b1;
                Error_o    = (err_code_q != ERR_NONE);
                Err_Code_o = err_code_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the whole request on accept so the address stays stable to completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q    <= 1'b0;
            size_q     <= SZ_BYTE;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_code_q <= ERR_NONE;
        end else if (accept) begin
            write_q    <= Write_i;
            size_q     <= Size_i;
            unsigned_q <= Unsigned_i;
            addr_q     <= Address_i;
            wdata_q    <= Write_Data_i;
            err_code_q <= req_err;
        end
    end

    // Register merged store word and the extended load result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            merged_q    <= '0;
            load_data_q <= '0;
        end else begin
            if (state_q == ST_RMW_READ) merged_q <= lane_merge;
            if (state_q == ST_LOAD && !write_q) load_data_q <= lane_load;
        end
    end

    assign Mem_Address_o = {addr_q[31:2], 2'b00};
    assign Load_Data_o   = load_data_q;

endmodule
